// File: rtl/hazard_stall_pkg.sv
// Shared encodings and types for the hazard/stall controller and its MDU busy counter.
// Tuse/Tnew latency codes, default MDU occupancy, shadow-pipeline entry type and compare helpers.
package hazard_stall_pkg;

    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;
    localparam logic [1:0] TUSE_NONE   = 2'd3;

    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef logic [4:0] reg_idx_t;
    typedef logic [1:0] lat_t;

    typedef struct packed {
        reg_idx_t a3;
        lat_t     tnew;
    } shadow_t;

    // Remaining latency one stage later; a result that is already bypassable stays at 0.
    function automatic lat_t tnew_dec(lat_t t);
        return (t == TNEW_JAL) ? TNEW_JAL : lat_t'(t - 2'd1);
    endfunction

    function automatic logic src_hazard(reg_idx_t src, lat_t tuse, shadow_t ex, shadow_t mem);
        logic live;
        live = (tuse != TUSE_NONE) && (src != '0);
        return live && (((src == ex.a3) && (tuse < ex.tnew)) ||
                        ((src == mem.a3) && (tuse < mem.tnew)));
    endfunction

endpackage

// File: rtl/hazard_stall_if.sv
// ID-stage operand/destination info in, stall and tracked producer state out.
// master: the pipeline core; slave: the hazard controller.
interface hazard_stall_if;
    import hazard_stall_pkg::*;

    reg_idx_t id_rs;
    reg_idx_t id_rt;
    lat_t     id_tuse_rs;
    lat_t     id_tuse_rt;
    reg_idx_t id_a3;
    lat_t     id_tnew;
    logic     id_md_start;
    logic     id_md_div;
    logic     id_md_use;
    logic     flush;

    logic     stall;
    logic     md_busy;
    reg_idx_t ex_a3;
    reg_idx_t mem_a3;
    lat_t     ex_tnew;
    lat_t     mem_tnew;

    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_a3, id_tnew,
               id_md_start, id_md_div, id_md_use, flush,
        input  stall, md_busy, ex_a3, mem_a3, ex_tnew, mem_tnew
    );

    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_a3, id_tnew,
               id_md_start, id_md_div, id_md_use, flush,
        output stall, md_busy, ex_a3, mem_a3, ex_tnew, mem_tnew
    );

endinterface

// File: rtl/hazard_mdu_cnt.sv
// HI/LO multiply/divide occupancy counter: loads the operation length on issue, counts down to idle.
// Decrement runs regardless of pipeline stall/flush so an issued operation always completes.
module hazard_mdu_cnt
    import hazard_stall_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic div_i,
    output logic busy_o
);

    localparam int CW = $clog2(DIV_CYC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        // NOTE: default the next-state value first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (load_i) begin
            cnt_d = div_i ? DIV_LD : MULT_LD;
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall.sv
// Hazard/stall controller: shadows EX/MEM producers {a3, Tnew} and freezes IF/ID when no bypass is in time.
// Define HAZARD_MDU_EN to include the HI/LO busy counter and MDU hazard; otherwise md_busy is tied 0.
module hazard_stall
    import hazard_stall_pkg::*;
`ifdef HAZARD_MDU_EN
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
)
`endif
(
    input logic           clk,
    input logic           reset_n,
    hazard_stall_if.slave hz
);

    shadow_t ex_q;
    shadow_t ex_d;
    shadow_t mem_q;
    shadow_t mem_d;
    logic    data_hz;
    logic    md_hz;
    logic    md_busy;
    logic    stall;

    always_comb begin
        data_hz = src_hazard(hz.id_rs, hz.id_tuse_rs, ex_q, mem_q) ||
                  src_hazard(hz.id_rt, hz.id_tuse_rt, ex_q, mem_q);
    end

`ifdef HAZARD_MDU_EN
    logic md_load;

    // An MDU op only loads the counter once it actually leaves ID.
    assign md_load = !stall && hz.id_md_start;
    assign md_hz   = (hz.id_md_start || hz.id_md_use) && md_busy;

    hazard_mdu_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_mdu_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (md_load),
        .div_i   (hz.id_md_div),
        .busy_o  (md_busy)
    );
`else
    assign md_busy = 1'b0;
    assign md_hz   = 1'b0;
`endif

    assign stall = !hz.flush && (data_hz || md_hz);

    always_comb begin
        mem_d.a3   = ex_q.a3;
        mem_d.tnew = tnew_dec(ex_q.tnew);
        ex_d       = stall ? shadow_t'('0) : shadow_t'({hz.id_a3, hz.id_tnew});
        if (hz.flush) begin
            ex_d  = '0;
            mem_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign hz.stall    = stall;
    assign hz.md_busy  = md_busy;
    assign hz.ex_a3    = ex_q.a3;
    assign hz.ex_tnew  = ex_q.tnew;
    assign hz.mem_a3   = mem_q.a3;
    assign hz.mem_tnew = mem_q.tnew;

endmodule
